// File: rtl/spmm_pkg.sv
// spmm_pkg: shared constants, FSM state encoding and the job command layout
// for the SpMM job controller.
package spmm_pkg;
  localparam int N = 16;
  localparam int LGN = $clog2(N);
  localparam int RHS_BEATS = N / 4;
  localparam int PE_DELAY = LGN + 2;
  localparam int RBW = (RHS_BEATS > 1) ? $clog2(RHS_BEATS) : 1;
  localparam int CW = LGN + 1;
  typedef enum logic [3:0] {
    IDLE, RHS_WAIT, RHS_LOAD, LHS_WAIT, LHS_RUN, PE_WAIT, OUT_WAIT, OUT_RUN, DONE
  } state_t;
  typedef struct packed {
    logic ws;
    logic os;
    logic drain;
  } job_cmd_t;
endpackage

// File: rtl/spmm_beat_ctr.sv
// spmm_beat_ctr: loadable down-counter shared by every timed phase.
//   start/len : load len (cycles remaining) on start
//   cnt       : remaining count, saturates at 0
//   last      : final cycle of the current phase (cnt <= 1)
module spmm_beat_ctr
  import spmm_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [CW-1:0] len,
  output logic [CW-1:0] cnt,
  output logic          last
);
  logic [CW-1:0] cnt_d, cnt_q;
  always_comb cnt_d = start ? len : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
  always_ff @(posedge clock) cnt_q <= reset ? '0 : cnt_d;
  assign cnt = cnt_q;
  assign last = cnt_q <= CW'(1);
endmodule

// File: rtl/spmm_job_ctrl.sv
// spmm_job_ctrl: job-level sequencer driving the SpMM array start strobes.
//   clock/reset       : clock, synchronous active-high reset
//   cmd_*             : host job handshake (ws, os, drain mode bits)
//   *_ready           : array readiness inputs
//   rhs/lhs/out_start : one-cycle strobes to the array, lhs_ws/lhs_os with lhs_start
//   *_beat/_valid,idx : per-beat host strobes and indices
//   job_done, busy    : completion pulse, not-idle flag
//   SPMM_JOB_CTRL_PERF_EN adds perf_busy_cyc / perf_stall_cyc counters.
module spmm_job_ctrl
  import spmm_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic           cmd_ws,
  input  logic           cmd_os,
  input  logic           cmd_drain,
  input  logic           rhs_ready,
  input  logic           lhs_ready_ns,
  input  logic           lhs_ready_ws,
  input  logic           lhs_ready_os,
  input  logic           lhs_ready_wos,
  input  logic           out_ready,
  output logic           rhs_start,
  output logic           lhs_start,
  output logic           out_start,
  output logic           lhs_ws,
  output logic           lhs_os,
  output logic           rhs_beat,
  output logic [RBW-1:0] rhs_idx,
  output logic           lhs_beat,
  output logic [LGN-1:0] lhs_idx,
  output logic           out_valid,
  output logic [RBW-1:0] out_idx,
  output logic           job_done,
  output logic           busy
`ifdef SPMM_JOB_CTRL_PERF_EN
  ,
  output logic [31:0]    perf_busy_cyc,
  output logic [31:0]    perf_stall_cyc
`endif
);
  state_t state_d, state_q;
  job_cmd_t job_d, job_q;
  logic rhs_kept_d, rhs_kept_q, acc_pending_d, acc_pending_q;
  logic ctr_start, ctr_last, lhs_rdy_sel;
  logic [CW-1:0] ctr_len, ctr_cnt;
  spmm_beat_ctr u_ctr (
    .clock(clock),
    .reset(reset),
    .start(ctr_start),
    .len(ctr_len),
    .cnt(ctr_cnt),
    .last(ctr_last)
  );
  assign lhs_rdy_sel = job_q.ws ? (job_q.os ? lhs_ready_wos : lhs_ready_ws)
                                : (job_q.os ? lhs_ready_os : lhs_ready_ns);
  // Each phase loads the counter with the beats still to come; the beat index
  // is then the phase length minus what remains.
  always_comb begin
    state_d = state_q;
    job_d = job_q;
    rhs_kept_d = rhs_kept_q;
    acc_pending_d = acc_pending_q;
    ctr_start = 1'b0;
    ctr_len = '0;
    cmd_ready = 1'b0;
    rhs_start = 1'b0;
    rhs_beat = 1'b0;
    lhs_start = 1'b0;
    lhs_beat = 1'b0;
    out_start = 1'b0;
    out_valid = 1'b0;
    job_done = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          job_d = '{ws: cmd_ws, os: cmd_os & acc_pending_q, drain: cmd_drain};
          state_d = rhs_kept_q ? LHS_WAIT : RHS_WAIT;
        end
      end
      RHS_WAIT:
        if (rhs_ready) begin
          rhs_start = 1'b1;
          rhs_beat = 1'b1;
          ctr_start = 1'b1;
          ctr_len = CW'(RHS_BEATS - 1);
          state_d = (RHS_BEATS == 1) ? LHS_WAIT : RHS_LOAD;
        end
      RHS_LOAD: begin
        rhs_beat = 1'b1;
        if (ctr_last) state_d = LHS_WAIT;
      end
      LHS_WAIT:
        if (lhs_rdy_sel) begin
          lhs_start = 1'b1;
          lhs_beat = 1'b1;
          ctr_start = 1'b1;
          ctr_len = CW'(N - 1);
          state_d = LHS_RUN;
        end
      LHS_RUN: begin
        lhs_beat = 1'b1;
        if (ctr_last) begin
          ctr_start = 1'b1;
          ctr_len = CW'(PE_DELAY);
          state_d = PE_WAIT;
        end
      end
      PE_WAIT: if (ctr_last) state_d = job_q.drain ? OUT_WAIT : DONE;
      OUT_WAIT:
        if (out_ready) begin
          out_start = 1'b1;
          ctr_start = 1'b1;
          ctr_len = CW'(RHS_BEATS);
          state_d = OUT_RUN;
        end
      // Array output is registered, so data trails out_start by one cycle.
      OUT_RUN: begin
        out_valid = 1'b1;
        if (ctr_last) state_d = DONE;
      end
      DONE: begin
        job_done = 1'b1;
        rhs_kept_d = job_q.ws;
        acc_pending_d = ~job_q.drain;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign lhs_ws = lhs_start & job_q.ws;
  assign lhs_os = lhs_start & job_q.os;
  assign busy = state_q != IDLE;
  assign rhs_idx = (state_q == RHS_LOAD) ? RBW'(CW'(RHS_BEATS) - ctr_cnt) : '0;
  assign lhs_idx = (state_q == LHS_RUN) ? LGN'(CW'(N) - ctr_cnt) : '0;
  assign out_idx = (state_q == OUT_RUN) ? RBW'(CW'(RHS_BEATS) - ctr_cnt) : '0;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      job_q <= '0;
      rhs_kept_q <= 1'b0;
      acc_pending_q <= 1'b0;
    end else begin
      state_q <= state_d;
      job_q <= job_d;
      rhs_kept_q <= rhs_kept_d;
      acc_pending_q <= acc_pending_d;
    end
  end
`ifdef SPMM_JOB_CTRL_PERF_EN
  logic [31:0] perf_busy_d, perf_busy_q, perf_stall_d, perf_stall_q;
  logic stalling;
  assign stalling = state_q == RHS_WAIT || state_q == LHS_WAIT || state_q == OUT_WAIT;
  always_comb begin
    perf_busy_d = perf_busy_q + 32'(busy && perf_busy_q != '1);
    perf_stall_d = perf_stall_q + 32'(stalling && perf_stall_q != '1);
  end
  always_ff @(posedge clock) begin
    perf_busy_q <= reset ? '0 : perf_busy_d;
    perf_stall_q <= reset ? '0 : perf_stall_d;
  end
  assign perf_busy_cyc = perf_busy_q;
  assign perf_stall_cyc = perf_stall_q;
`endif
endmodule

// File: tb/tb_spmm_job_ctrl.sv
// tb_spmm_job_ctrl: randomized job/ready stimulus checked cycle by cycle
// against a schedule model derived from the job timing rules.
module tb_spmm_job_ctrl;
  localparam int N = 16;
  localparam int RB = N / 4;
  localparam int PED = $clog2(N) + 2;
  localparam int MAXC = 200;
  logic clock = 1'b0, reset = 1'b1;
  logic cmd_valid = 1'b0, cmd_ws = 1'b0, cmd_os = 1'b0, cmd_drain = 1'b0;
  logic rhs_ready = 1'b0, lhs_ready_ns = 1'b0, lhs_ready_ws = 1'b0;
  logic lhs_ready_os = 1'b0, lhs_ready_wos = 1'b0, out_ready = 1'b0;
  logic cmd_ready, rhs_start, lhs_start, out_start, lhs_ws, lhs_os;
  logic rhs_beat, lhs_beat, out_valid, job_done, busy;
  logic [1:0] rhs_idx, out_idx;
  logic [3:0] lhs_idx;
`ifdef SPMM_JOB_CTRL_PERF_EN
  logic [31:0] perf_busy_cyc, perf_stall_cyc;
`endif
  int checks = 0, errors = 0;
  int n_done = 0, n_rhs = 0, n_out = 0;
  bit m_kept = 0, m_acc = 0;
  bit rdy [6][MAXC];
  always #5 clock = ~clock;
  spmm_job_ctrl dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ws(cmd_ws), .cmd_os(cmd_os), .cmd_drain(cmd_drain),
    .rhs_ready(rhs_ready),
    .lhs_ready_ns(lhs_ready_ns), .lhs_ready_ws(lhs_ready_ws),
    .lhs_ready_os(lhs_ready_os), .lhs_ready_wos(lhs_ready_wos),
    .out_ready(out_ready),
    .rhs_start(rhs_start), .lhs_start(lhs_start), .out_start(out_start),
    .lhs_ws(lhs_ws), .lhs_os(lhs_os),
    .rhs_beat(rhs_beat), .rhs_idx(rhs_idx),
    .lhs_beat(lhs_beat), .lhs_idx(lhs_idx),
    .out_valid(out_valid), .out_idx(out_idx),
    .job_done(job_done), .busy(busy)
`ifdef SPMM_JOB_CTRL_PERF_EN
    , .perf_busy_cyc(perf_busy_cyc), .perf_stall_cyc(perf_stall_cyc)
`endif
  );
  logic [31:0] obs;
  assign obs = 32'({cmd_ready, busy, rhs_start, rhs_beat, rhs_idx, lhs_start, lhs_ws, lhs_os,
                    lhs_beat, lhs_idx, out_start, out_valid, out_idx, job_done});
  function automatic logic [31:0] pk(bit cr, bit bz, bit rs, bit rb, logic [1:0] ri,
                                     bit ls, bit lw, bit lo, bit lb, logic [3:0] li,
                                     bit os, bit ov, logic [1:0] oi, bit jd);
    return 32'({cr, bz, rs, rb, ri, ls, lw, lo, lb, li, os, ov, oi, jd});
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic int first(int r, int t);
    int k = t;
    while (k < MAXC - 1 && !rdy[r][k]) k++;
    return k;
  endfunction
  task automatic tally();
    n_done += int'(job_done);
    n_rhs += int'(rhs_start);
    n_out += int'(out_start);
  endtask
  task automatic drive_ready(input int k);
    rhs_ready = rdy[0][k];
    lhs_ready_ns = rdy[1][k];
    lhs_ready_os = rdy[2][k];
    lhs_ready_ws = rdy[3][k];
    lhs_ready_wos = rdy[4][k];
    out_ready = rdy[5][k];
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cmd_valid = 1'b0;
      reset = 1'b0;
      for (int r = 0; r < 6; r++) rdy[r][0] = $urandom_range(0, 1) != 0;
      drive_ready(0);
      @(negedge clock);
      tally();
      check("idle", obs, pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clock);
      #1;
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    m_kept = 0;
    m_acc = 0;
  endtask
  // Schedule: each wait ends at the first cycle its ready is high; beat
  // phases have fixed lengths; output data follows out_start by one cycle.
  task automatic run_job(input bit ws, input bit os, input bit drain, input int stall,
                         input bit all_rdy, input bit abort, output int done_k);
    int rs, ls, os_k, dn, t, last, ab_k;
    bit oe, kept;
    logic [1:0] ri, oi;
    logic [3:0] li;
    bit rb, lb, ov;
    for (int r = 0; r < 6; r++)
      for (int k = 0; k < MAXC; k++) rdy[r][k] = all_rdy ? 1'b1 : ($urandom_range(0, 3) != 0);
    for (int k = 1; k <= stall; k++) rdy[0][k] = 1'b0;
    kept = m_kept;
    oe = os & m_acc;
    t = 1;
    rs = -1;
    if (!kept) begin
      rs = first(0, t);
      t = rs + RB;
    end
    ls = first(1 + int'({ws, oe}), t);
    t = ls + N + PED;
    os_k = -1;
    if (drain) begin
      os_k = first(5, t);
      t = os_k + RB + 1;
    end
    dn = t;
    ab_k = abort ? ls + 7 : -1;
    last = abort ? ab_k : dn;
    if (last > MAXC - 1) last = MAXC - 1;
    done_k = -1;
    for (int k = 0; k <= last; k++) begin
      cmd_valid = 1'b1;
      cmd_ws = (k == 0) ? ws : 1'($urandom_range(0, 1));
      cmd_os = (k == 0) ? os : 1'($urandom_range(0, 1));
      cmd_drain = (k == 0) ? drain : 1'($urandom_range(0, 1));
      reset = k == ab_k;
      drive_ready(k);
      rb = !kept && k >= rs && k < rs + RB;
      lb = k >= ls && k < ls + N;
      ov = drain && k > os_k && k <= os_k + RB;
      ri = rb ? 2'(k - rs) : 2'd0;
      li = lb ? 4'(k - ls) : 4'd0;
      oi = ov ? 2'(k - os_k - 1) : 2'd0;
      @(negedge clock);
      tally();
      if (job_done && done_k < 0) done_k = k;
      check($sformatf("cyc%0d", k), obs,
            pk(k == 0, k != 0, !kept && k == rs, rb, ri, k == ls, k == ls && ws, k == ls && oe,
               lb, li, drain && k == os_k, ov, oi, k == dn));
      @(posedge clock);
      #1;
    end
    reset = 1'b0;
    cmd_valid = 1'b0;
    if (abort) begin
      m_kept = 0;
      m_acc = 0;
    end else begin
      check("done_at", 32'(done_k), 32'(dn));
      m_kept = ws;
      m_acc = !drain;
    end
  endtask
  initial begin
    int dk, d0, r0, o0;
    bit ab;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    idle(2);
    run_job(0, 0, 1, 0, 1, 0, dk);
    check("lat_ns", 32'(dk), 32'(2 + RB + N + PED + RB + 0));
    idle(1);
    r0 = n_rhs;
    run_job(1, 0, 1, 0, 0, 0, dk);
    check("a_rhs", 32'(n_rhs - r0), 1);
    r0 = n_rhs;
    run_job(0, 0, 1, 0, 0, 0, dk);
    check("b_no_rhs", 32'(n_rhs - r0), 0);
    do_reset();
    idle(1);
    run_job(0, 1, 1, 0, 0, 0, dk);
    o0 = n_out;
    run_job(0, 0, 0, 0, 0, 0, dk);
    check("nodrain_out", 32'(n_out - o0), 0);
    run_job(0, 1, 1, 0, 0, 0, dk);
    idle(1);
    run_job(0, 0, 1, 10, 1, 0, dk);
    check("lat_stall", 32'(dk), 32'(2 + RB + N + PED + RB + 10));
    d0 = n_done;
    run_job(1, 0, 1, 0, 1, 1, dk);
    idle(1);
    check("abort_done", 32'(n_done - d0), 0);
    r0 = n_rhs;
    run_job(0, 0, 1, 0, 1, 0, dk);
    check("reload_rhs", 32'(n_rhs - r0), 1);
    d0 = n_done;
    for (int j = 0; j < 3; j++)
      run_job(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              0, 0, 0, dk);
    check("b2b_done", 32'(n_done - d0), 3);
    for (int j = 0; j < 24; j++) begin
      ab = $urandom_range(0, 7) == 0;
      run_job(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              0, 0, ab, dk);
      idle(ab ? 1 : $urandom_range(0, 2));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
